// File: rtl/data_bus_arbiter_pkg.sv
// data_bus_arbiter_pkg: shared state encodings and defaults for the data bus arbiter
package data_bus_arbiter_pkg;
    typedef enum logic {ARB_IDLE = 1'b0, ARB_BUSY = 1'b1} arb_state_t;
    localparam int DEFAULT_TIMEOUT = 255;
endpackage

// File: rtl/data_bus_arbiter_rr_pointer.sv
// rr_pointer: combinational two-requester round-robin picker
module rr_pointer (
    input  logic [1:0] i_req,
    input  logic       i_prio,
    output logic       o_winner,
    output logic       o_valid
);
    assign o_valid  = |i_req;
    assign o_winner = (&i_req) ? i_prio : i_req[1];
endmodule

// File: rtl/data_bus_arbiter.sv
// data_bus_arbiter: round-robin two-master, one-slave data bus arbiter
// with one outstanding transaction and a bounded slave wait
module data_bus_arbiter
    import data_bus_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    m0_req,
    input  logic                    m0_we,
    input  logic [ADDR_WIDTH-1:0]   m0_addr,
    input  logic [DATA_WIDTH-1:0]   m0_wdata,
    input  logic [DATA_WIDTH/8-1:0] m0_mask,
    output logic                    m0_ack,
    output logic                    m0_err,
    output logic [DATA_WIDTH-1:0]   m0_rdata,
    input  logic                    m1_req,
    input  logic                    m1_we,
    input  logic [ADDR_WIDTH-1:0]   m1_addr,
    input  logic [DATA_WIDTH-1:0]   m1_wdata,
    input  logic [DATA_WIDTH/8-1:0] m1_mask,
    output logic                    m1_ack,
    output logic                    m1_err,
    output logic [DATA_WIDTH-1:0]   m1_rdata,
    output logic                    s_req,
    output logic                    s_we,
    output logic [ADDR_WIDTH-1:0]   s_addr,
    output logic [DATA_WIDTH-1:0]   s_wdata,
    output logic [DATA_WIDTH/8-1:0] s_mask,
    input  logic                    s_ack,
    input  logic [DATA_WIDTH-1:0]   s_rdata,
    output logic                    grant
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    arb_state_t              r_state;
    logic                    r_prio;
    logic                    r_grant;
    logic [CW-1:0]           r_cnt;
    logic                    r_we;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [DATA_WIDTH/8-1:0] r_mask;
    logic                    w_winner;
    logic                    w_valid;
    logic                    w_busy;
    logic                    w_done;
    logic                    w_timeout;
    logic                    w_ok;

    rr_pointer u_rr (
        .i_req    ({m1_req, m0_req}),
        .i_prio   (r_prio),
        .o_winner (w_winner),
        .o_valid  (w_valid)
    );

    assign w_busy    = (r_state == ARB_BUSY);
    assign w_ok      = w_busy && s_ack;
    // s_ack has precedence over expiry in the same cycle
    assign w_timeout = w_busy && !s_ack && (r_cnt == LAST);
    assign w_done    = w_ok || w_timeout;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ARB_IDLE;
            r_prio  <= 1'b0;
            r_grant <= 1'b0;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_mask  <= '0;
        end else if (r_state == ARB_IDLE) begin
            if (w_valid) begin
                r_state <= ARB_BUSY;
                r_grant <= w_winner;
                r_cnt   <= '0;
                r_we    <= w_winner ? m1_we    : m0_we;
                r_addr  <= w_winner ? m1_addr  : m0_addr;
                r_wdata <= w_winner ? m1_wdata : m0_wdata;
                r_mask  <= w_winner ? m1_mask  : m0_mask;
            end
        end else if (w_done) begin
            r_state <= ARB_IDLE;
            r_prio  <= ~r_grant;
        end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign s_req    = w_busy;
    assign s_we     = r_we;
    assign s_addr   = r_addr;
    assign s_wdata  = r_wdata;
    assign s_mask   = r_mask;
    assign grant    = r_grant;
    assign m0_ack   = w_done && !r_grant;
    assign m1_ack   = w_done && r_grant;
    assign m0_err   = w_timeout && !r_grant;
    assign m1_err   = w_timeout && r_grant;
    assign m0_rdata = (w_ok && !r_grant) ? s_rdata : '0;
    assign m1_rdata = (w_ok && r_grant) ? s_rdata : '0;
endmodule

// File: tb/tb_data_bus_arbiter.sv
// tb_data_bus_arbiter: directed scenario tests for data_bus_arbiter (TIMEOUT = 4)
module tb_data_bus_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_mask, m1_mask;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_req, s_we, s_ack, grant;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_mask;
    int          errors = 0;
    int          checks = 0;

    data_bus_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_mask(m0_mask),
        .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_mask(m1_mask),
        .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
        .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata), .s_mask(s_mask),
        .s_ack(s_ack), .s_rdata(s_rdata), .grant(grant)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0; m0_mask = 0;
        m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0; m1_mask = 0;
        s_ack = 0; s_rdata = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL reset_s_req got=%0b exp=0", s_req); end
        checks++; if (grant !== 1'b0) begin errors++; $display("FAIL reset_grant got=%0b exp=0", grant); end
        checks++; if ({s_we, s_addr, s_wdata, s_mask} !== 69'd0) begin errors++; $display("FAIL reset_slave_regs got=%0h exp=0", {s_we, s_addr, s_wdata, s_mask}); end
        checks++; if ({m0_ack, m0_err, m1_ack, m1_err} !== 4'b0) begin errors++; $display("FAIL reset_acks got=%04b exp=0000", {m0_ack, m0_err, m1_ack, m1_err}); end
        checks++; if ({m0_rdata, m1_rdata} !== 64'd0) begin errors++; $display("FAIL reset_rdata got=%0h exp=0", {m0_rdata, m1_rdata}); end
    endtask

    task automatic test_single_read();
        do_reset();
        m0_req = 1; m0_we = 0; m0_addr = 32'h100;
        @(negedge clk);
        s_ack = 1; s_rdata = 32'hCAFEBABE;
        #1;
        checks++; if (s_req !== 1'b1 || s_addr !== 32'h100 || s_we !== 1'b0) begin errors++; $display("FAIL single_slave got req=%0b addr=%0h we=%0b exp req=1 addr=100 we=0", s_req, s_addr, s_we); end
        checks++; if (m0_ack !== 1'b1 || m0_err !== 1'b0) begin errors++; $display("FAIL single_ack got ack=%0b err=%0b exp ack=1 err=0", m0_ack, m0_err); end
        checks++; if (m0_rdata !== 32'hCAFEBABE) begin errors++; $display("FAIL single_rdata got=%0h exp=cafebabe", m0_rdata); end
        checks++; if (m1_ack !== 1'b0 || m1_rdata !== 32'd0) begin errors++; $display("FAIL single_m1_quiet got ack=%0b rdata=%0h exp 0", m1_ack, m1_rdata); end
        @(negedge clk);
        m0_req = 0; s_ack = 0;
        #1;
        checks++; if (s_req !== 1'b0 || m0_ack !== 1'b0) begin errors++; $display("FAIL single_idle got s_req=%0b ack=%0b exp 0", s_req, m0_ack); end
    endtask

    task automatic test_contention();
        logic [31:0] exp_addr;
        do_reset();
        m0_req = 1; m0_addr = 32'h10; m1_req = 1; m1_addr = 32'h20;
        s_ack = 1; s_rdata = 32'h55AA55AA;
        for (int k = 0; k < 4; k++) begin
            exp_addr = k[0] ? 32'h20 : 32'h10;
            @(negedge clk); #1;
            checks++; if (s_req !== 1'b1 || grant !== k[0]) begin errors++; $display("FAIL contention_grant%0d got req=%0b grant=%0b exp req=1 grant=%0b", k, s_req, grant, k[0]); end
            checks++; if (s_addr !== exp_addr) begin errors++; $display("FAIL contention_addr%0d got=%0h exp=%0h", k, s_addr, exp_addr); end
            checks++; if (m0_ack !== !k[0] || m1_ack !== k[0]) begin errors++; $display("FAIL contention_ack%0d got m0=%0b m1=%0b exp m0=%0b m1=%0b", k, m0_ack, m1_ack, !k[0], k[0]); end
            @(negedge clk); #1;
            checks++; if (s_req !== 1'b0 || m0_ack !== 1'b0 || m1_ack !== 1'b0) begin errors++; $display("FAIL contention_idle%0d got req=%0b acks=%0b%0b exp 0", k, s_req, m0_ack, m1_ack); end
        end
        m0_req = 0; m1_req = 0; s_ack = 0;
    endtask

    task automatic test_write_wait();
        do_reset();
        m1_req = 1; m1_we = 1; m1_addr = 32'h204; m1_wdata = 32'h12345678; m1_mask = 4'b0011;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            s_ack = (c == 3);
            #1;
            checks++; if (s_req !== 1'b1 || grant !== 1'b1 || s_we !== 1'b1 || s_addr !== 32'h204 || s_wdata !== 32'h12345678 || s_mask !== 4'b0011)
                begin errors++; $display("FAIL write_stable%0d got req=%0b grant=%0b we=%0b addr=%0h wdata=%0h mask=%0b", c, s_req, grant, s_we, s_addr, s_wdata, s_mask); end
            checks++; if (m1_ack !== (c == 3) || m1_err !== 1'b0 || m0_ack !== 1'b0) begin errors++; $display("FAIL write_ack%0d got m1_ack=%0b err=%0b m0_ack=%0b exp m1_ack=%0b err=0", c, m1_ack, m1_err, m0_ack, c == 3); end
            m1_addr = 32'hFFF0; m1_wdata = 32'h0; m1_mask = 4'b1111; m1_we = 0;
        end
        @(negedge clk);
        m1_req = 0; s_ack = 0;
        #1;
        checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL write_idle got s_req=%0b exp=0", s_req); end
    endtask

    task automatic test_timeout();
        do_reset();
        m0_req = 1; m0_addr = 32'h300; s_rdata = 32'hDEADBEEF;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk); #1;
            checks++; if (s_req !== 1'b1 || m0_ack !== (c == 4) || m0_err !== (c == 4)) begin errors++; $display("FAIL timeout_c%0d got req=%0b ack=%0b err=%0b exp req=1 ack=err=%0b", c, s_req, m0_ack, m0_err, c == 4); end
        end
        checks++; if (m0_rdata !== 32'd0 || m1_ack !== 1'b0) begin errors++; $display("FAIL timeout_rdata got rdata=%0h m1_ack=%0b exp 0", m0_rdata, m1_ack); end
        @(negedge clk);
        m0_req = 0; s_ack = 1;
        #1;
        checks++; if (s_req !== 1'b0 || m0_ack !== 1'b0 || m0_err !== 1'b0 || m0_rdata !== 32'd0) begin errors++; $display("FAIL timeout_stray got req=%0b ack=%0b err=%0b rdata=%0h exp 0", s_req, m0_ack, m0_err, m0_rdata); end
        s_ack = 0;
    endtask

    task automatic test_ack_at_expiry();
        do_reset();
        m0_req = 1; m0_addr = 32'h304; s_rdata = 32'h0BADF00D;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            s_ack = (c == 4);
            #1;
        end
        checks++; if (m0_ack !== 1'b1 || m0_err !== 1'b0 || m0_rdata !== 32'h0BADF00D) begin errors++; $display("FAIL expiry_ack got ack=%0b err=%0b rdata=%0h exp ack=1 err=0 rdata=badf00d", m0_ack, m0_err, m0_rdata); end
        @(negedge clk);
        m0_req = 0; s_ack = 0;
    endtask

    task automatic test_drop_req();
        do_reset();
        m0_req = 1; m0_addr = 32'h400;
        @(negedge clk);
        m0_req = 0;
        #1;
        checks++; if (s_req !== 1'b1 || m0_ack !== 1'b0) begin errors++; $display("FAIL drop_busy got req=%0b ack=%0b exp req=1 ack=0", s_req, m0_ack); end
        @(negedge clk);
        s_ack = 1;
        #1;
        checks++; if (s_req !== 1'b1 || m0_ack !== 1'b1) begin errors++; $display("FAIL drop_ack got req=%0b ack=%0b exp 1 1", s_req, m0_ack); end
        @(negedge clk);
        s_ack = 0;
        #1;
        checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL drop_idle1 got s_req=%0b exp=0", s_req); end
        @(negedge clk); #1;
        checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL drop_idle2 got s_req=%0b exp=0", s_req); end
    endtask

    task automatic test_reset_busy();
        do_reset();
        m0_req = 1; m0_addr = 32'h500;
        @(negedge clk);
        s_ack = 1;
        @(negedge clk);
        m0_req = 0; s_ack = 0;
        m1_req = 1; m1_we = 1; m1_addr = 32'h600; m1_wdata = 32'hA5A5A5A5; m1_mask = 4'b1111;
        @(negedge clk); #1;
        checks++; if (s_req !== 1'b1 || grant !== 1'b1) begin errors++; $display("FAIL rbusy_pre got req=%0b grant=%0b exp 1 1", s_req, grant); end
        reset = 1; m0_req = 1;
        @(negedge clk);
        reset = 0;
        #1;
        checks++; if (s_req !== 1'b0 || grant !== 1'b0 || {s_we, s_addr, s_wdata, s_mask} !== 69'd0) begin errors++; $display("FAIL rbusy_outputs got req=%0b grant=%0b we=%0b addr=%0h wdata=%0h mask=%0b exp 0", s_req, grant, s_we, s_addr, s_wdata, s_mask); end
        checks++; if ({m0_ack, m0_err, m1_ack, m1_err} !== 4'b0) begin errors++; $display("FAIL rbusy_acks got=%04b exp=0000", {m0_ack, m0_err, m1_ack, m1_err}); end
        @(negedge clk); #1;
        checks++; if (s_req !== 1'b1 || grant !== 1'b0 || s_addr !== 32'h500) begin errors++; $display("FAIL rbusy_regrant got req=%0b grant=%0b addr=%0h exp req=1 grant=0 addr=500", s_req, grant, s_addr); end
        m0_req = 0; m1_req = 0;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_contention();
        test_write_wait();
        test_timeout();
        test_ack_at_expiry();
        test_drop_req();
        test_reset_busy();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/data_bus_arbiter.md
# data_bus_arbiter

Two-master, single-slave arbiter for the core's data-memory bus. It shares one data memory/peripheral port between the CPU load/store port (master 0) and a DMA/debug master (master 1). Arbitration is round-robin, with one outstanding transaction at a time and a bounded wait on the slave. The block sits between the CPU's `memAddr`/`memWriteData`/`wrMask`/`memWr` outputs, the second master, and the memory bus.

## Interface
- `ADDR_WIDTH`, 32, address width.
- `DATA_WIDTH`, 32, data width; byte-mask width is `DATA_WIDTH/8`.
- `TIMEOUT`, 255, maximum number of cycles spent in BUSY waiting for `s_ack`; minimum 1.

Ports:
- `clk` in 1: clock. All state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `m0_req`, `m1_req` in 1: transaction request; held by the master until its ack.
- `m0_we`, `m1_we` in 1: write enable; 1 = write, 0 = read.
- `m0_addr`, `m1_addr` in `ADDR_WIDTH`: byte address.
- `m0_wdata`, `m1_wdata` in `DATA_WIDTH`: write data, already lane-aligned.
- `m0_mask`, `m1_mask` in `DATA_WIDTH/8`: byte write mask.
- `m0_ack`, `m1_ack` out 1: one-cycle completion pulse.
- `m0_err`, `m1_err` out 1: valid with ack; 1 = timed out.
- `m0_rdata`, `m1_rdata` out `DATA_WIDTH`: read data, valid with ack.
- `s_req` out 1: slave request.
- `s_we` out 1: slave write enable.
- `s_addr` out `ADDR_WIDTH`: slave address.
- `s_wdata` out `DATA_WIDTH`: slave write data.
- `s_mask` out `DATA_WIDTH/8`: slave byte mask.
- `s_ack` in 1: slave completion.
- `s_rdata` in `DATA_WIDTH`: slave read data, valid with `s_ack`.
- `grant` out 1: index of the owning master, valid while `s_req` is high.

## Operation
- FSM states:
  - IDLE: no transaction in flight.
  - BUSY: latched request presented to the slave.
- IDLE, arbitration:
  - Winner is the requesting master. If both request, the winner is the one indicated by priority pointer `prio`.
  - On the clock edge, latch the winner's we/addr/wdata/mask into the slave output registers, set `grant`, clear the wait counter, go to BUSY.
  - With no request, stay in IDLE.
- BUSY:
  - `s_req` = 1; slave outputs hold the latched values.
  - `s_ack` = 1: `mX_ack` = 1 and `mX_rdata` = `s_rdata` combinationally, same cycle, for X = `grant`; `mX_err` = 0. Next state IDLE; `prio` ← ~`grant`.
  - Counter reaches `TIMEOUT` - 1 without `s_ack`: `mX_ack` = 1, `mX_err` = 1, `mX_rdata` = 0. Next state IDLE; `prio` ← ~`grant`. A later stray `s_ack` is ignored.
  - Otherwise: counter +1, saturating, `$clog2(TIMEOUT+1)` bits.
- Non-granted master: ack, err and rdata are all 0.
- Master drops req while in BUSY: the transaction still completes and the ack is still pulsed. The master must ignore it.
- Master inputs change while in BUSY: ignored, because outputs come from the latched registers.
- A master that keeps req high after its ack is a new request in the following IDLE cycle. It is rearbitrated against the other master with its priority now lowered.

## Timing
- Reset values (take effect on the reset edge):
  - State IDLE, `prio` = 0, counter = 0.
  - `s_req`, `s_we` = 0; `s_addr`, `s_wdata`, `s_mask` = 0; `grant` = 0.
  - All `mX_ack`, `mX_err`, `mX_rdata` = 0.
- Reset while BUSY: the transaction is abandoned without an ack, and `s_req` deasserts the next cycle.
- Latency, with req asserted at cycle N in IDLE:
  - `s_req` high at N+1.
  - Zero-wait slave (`s_ack` at N+1): ack at N+1.
  - Best case is two cycles per transaction, including one IDLE cycle.
- Timeout: err ack occurs in the `TIMEOUT`-th BUSY cycle.
- Simultaneous requests: strict alternation, so each master waits at most one transaction.
- Single-master throughput with a zero-wait slave: one transaction per 2 cycles.
- Simultaneous `s_ack` and counter expiry in the same cycle: `s_ack` wins and err = 0.

## Structure
- Shared package / header `src/constants.vh`: state encodings `ARB_IDLE`, `ARB_BUSY` and the default `TIMEOUT`.
- One natural sub-module, `rr_pointer`: a 2-requester round-robin picker. Inputs are req[1:0] and prio; outputs are winner and valid. It is purely combinational and reused for future N-master versions.
- Everything else stays in `data_bus_arbiter`: FSM, latch registers, counter and response demux.

## Test plan
- Single read: `m0_req` with addr 0x100, slave acks the first BUSY cycle with rdata 0xCAFEBABE. Required: `m0_ack` at N+1, `m0_rdata` = 0xCAFEBABE, `m1_ack` stays 0.
- Contention: both masters request continuously, slave is zero-wait. Required: grants go 0,1,0,1; each ack is paired with its own master's address on `s_addr`.
- Write with wait states: `m1` writes 0x12345678, mask 0b0011, to 0x204; slave acks after 3 BUSY cycles. Required:
  - `s_we`, `s_addr`, `s_wdata` and `s_mask` are stable for all 3 cycles.
  - `m1_ack` occurs in cycle 3 with err = 0.
- Timeout: `TIMEOUT` = 4, slave never acks. Required: `m0_ack` = 1, `m0_err` = 1, rdata = 0 in BUSY cycle 4, then IDLE; a late `s_ack` produces no ack.
- Request dropped mid-transaction: `m0` deasserts req while in BUSY. Required: the slave still completes, `m0_ack` still pulses, and no second transaction starts.
- Reset while BUSY: `s_req` = 0 and all outputs are at their reset values the cycle after reset; `prio` = 0, so with both masters requesting the next grant goes to `m0`.
